// File: rtl/clock_divider_multi.sv
`default_nettype none
// ============================================================================
// clock_divider_multi : NUM_CH glitch-free programmable clock dividers with
//                       shadowed divisor/high time, enable, period tick, sync
// Revision: 1.0
// ============================================================================
module clock_divider_multi #(
  parameter int NUM_CH      = 2,
  parameter int COUNT_WIDTH = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             en,
  input  logic [NUM_CH-1:0]             load,
  input  logic [NUM_CH*COUNT_WIDTH-1:0] div_in,
  input  logic [NUM_CH*COUNT_WIDTH-1:0] high_in,
  input  logic                          sync,
  output logic [NUM_CH-1:0]             out,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             pending
);

  localparam logic [COUNT_WIDTH-1:0] DIV_RST  = COUNT_WIDTH'(DEFAULT_DIV);
  localparam logic [COUNT_WIDTH-1:0] HIGH_RST = COUNT_WIDTH'(DEFAULT_DIV / 2);
  localparam logic [COUNT_WIDTH-1:0] DIV_MIN  = COUNT_WIDTH'(2);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t                  state, state_nx;
    logic [COUNT_WIDTH-1:0]  cnt, cnt_nx;
    logic [COUNT_WIDTH-1:0]  div_act, div_act_nx, high_act, high_act_nx;
    logic [COUNT_WIDTH-1:0]  div_sh, div_sh_nx, high_sh, high_sh_nx;
    logic [COUNT_WIDTH-1:0]  div_slice, div_cap, high_cap;
    logic                    out_q, out_nx, tick_q, tick_nx, pend_q, pend_nx;
    logic                    pend_cap, apply;

    assign div_slice = div_in[i*COUNT_WIDTH +: COUNT_WIDTH];

    // Shadow as it would look after this edge's load, so a load landing on a
    // wrap/sync edge is applied immediately instead of waiting a whole period.
    assign div_cap  = load[i] ? ((div_slice < DIV_MIN) ? DIV_MIN : div_slice) : div_sh;
    assign high_cap = load[i] ? high_in[i*COUNT_WIDTH +: COUNT_WIDTH] : high_sh;
    assign pend_cap = load[i] | pend_q;

    always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      div_act_nx  = div_act;
      high_act_nx = high_act;
      div_sh_nx   = div_cap;
      high_sh_nx  = high_cap;
      pend_nx     = pend_cap;
      apply       = 1'b0;
      tick_nx     = 1'b0;
      out_nx      = 1'b0;

      unique case (state)
        IDLE: begin
          cnt_nx = '0;
          if (en[i]) begin
            state_nx = RUN;
            tick_nx  = 1'b1;
          end else begin
            apply = pend_cap;
          end
        end
        RUN: begin
          if (!en[i]) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else if (sync || (cnt == div_act - COUNT_WIDTH'(1))) begin
            cnt_nx  = '0;
            tick_nx = 1'b1;
            apply   = pend_cap;
          end else begin
            cnt_nx = cnt + COUNT_WIDTH'(1);
          end
        end
        default: state_nx = IDLE;
      endcase

      if (apply) begin
        div_act_nx  = div_cap;
        high_act_nx = high_cap;
        pend_nx     = 1'b0;
      end

      // en=1 means the channel is in RUN after this edge, in either state.
      if (en[i]) out_nx = (cnt_nx < high_act_nx);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= IDLE;
        cnt      <= '0;
        div_act  <= DIV_RST;
        high_act <= HIGH_RST;
        div_sh   <= DIV_RST;
        high_sh  <= HIGH_RST;
        out_q    <= 1'b0;
        tick_q   <= 1'b0;
        pend_q   <= 1'b0;
      end else begin
        state    <= state_nx;
        cnt      <= cnt_nx;
        div_act  <= div_act_nx;
        high_act <= high_act_nx;
        div_sh   <= div_sh_nx;
        high_sh  <= high_sh_nx;
        out_q    <= out_nx;
        tick_q   <= tick_nx;
        pend_q   <= pend_nx;
      end
    end

    assign out[i]     = out_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
`default_nettype none
// ============================================================================
// tb_clock_divider_multi : directed scoreboard bench for clock_divider_multi
// Revision: 1.0
// ============================================================================
module tb_clock_divider_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sync = 1'b0;
  logic [1:0] en = 2'b00;
  logic [1:0] load = 2'b00;
  logic [7:0] div_in = 8'h00;
  logic [7:0] high_in = 8'h00;
  logic [1:0] out, tick, pending;

  clock_divider_multi #(
    .NUM_CH(2),
    .COUNT_WIDTH(4),
    .DEFAULT_DIV(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .load(load),
    .div_in(div_in),
    .high_in(high_in),
    .sync(sync),
    .out(out),
    .tick(tick),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] o;
    logic [1:0] t;
    logic [1:0] p;
  } exp_t;

  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  string stage  = "reset";

  // Expected-waveform generator: phase within the period of each channel.
  bit run[2];
  int ph[2];
  int dv[2];
  int hi[2];

  task automatic chk(string tag, logic [1:0] got, logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s: got %b expected %b", stage, tag, got, exp);
    end
  endtask

  // Push n expected cycles, then run n edges comparing against the queue.
  task automatic plan(int n, logic [1:0] pend);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e = '0;
      for (int c = 0; c < 2; c++) begin
        e.o[c] = run[c] && (ph[c] < hi[c]);
        e.t[c] = run[c] && (ph[c] == 0);
        if (run[c]) ph[c] = (ph[c] + 1) % dv[c];
      end
      e.p = pend;
      sb.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", 2'b01, 2'b00);
      end else begin
        e = sb.pop_front();
        chk("out", out, e.o);
        chk("tick", tick, e.t);
        chk("pending", pending, e.p);
      end
    end
  endtask

  initial begin
    run = '{0, 0};
    ph  = '{0, 0};
    dv  = '{6, 6};
    hi  = '{3, 3};

    // Asynchronous reset visible before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_out", out, 2'b00);
    chk("rst_tick", tick, 2'b00);
    chk("rst_pending", pending, 2'b00);

    // 1: default 6/3 pattern on ch0, ch1 stays idle.
    @(negedge clk);
    rst = 1'b0;
    stage = "default";
    en = 2'b01;
    run[0] = 1;
    plan(12, 2'b00);

    // 2: load 4/1 mid-period; old period finishes, new applies at the wrap.
    stage = "load_mid";
    plan(3, 2'b00);
    load = 2'b01; div_in[3:0] = 4'd4; high_in[3:0] = 4'd1;
    plan(1, 2'b01);
    load = 2'b00;
    plan(2, 2'b01);
    dv[0] = 4; hi[0] = 1;
    plan(8, 2'b00);

    // 3: load on the wrap edge applies at once; div=1 clamps to 2, high=0.
    stage = "clamp";
    load = 2'b01; div_in[3:0] = 4'd1; high_in[3:0] = 4'd0;
    dv[0] = 2; hi[0] = 0;
    plan(1, 2'b00);
    load = 2'b00;
    plan(6, 2'b00);
    stage = "high_ge_div";
    load = 2'b01; div_in[3:0] = 4'd5; high_in[3:0] = 4'd15;
    plan(1, 2'b01);
    load = 2'b00;
    dv[0] = 5; hi[0] = 15;
    plan(10, 2'b00);

    // 4: ch1 joins out of phase with a pending load; sync realigns and applies it.
    stage = "sync";
    plan(2, 2'b00);
    en = 2'b11;
    run[1] = 1; ph[1] = 0;
    plan(1, 2'b00);
    load = 2'b10; div_in[7:4] = 4'd5; high_in[7:4] = 4'd2;
    plan(2, 2'b10);
    load = 2'b00;
    sync = 1'b1;
    ph = '{0, 0};
    dv[1] = 5; hi[1] = 2;
    plan(1, 2'b00);
    sync = 1'b0;
    plan(10, 2'b00);

    // 5: asynchronous reset between edges with a load pending.
    stage = "async_rst";
    plan(1, 2'b00);
    load = 2'b10; div_in[7:4] = 4'd3; high_in[7:4] = 4'd1;
    plan(1, 2'b10);
    load = 2'b00;
    #3;
    rst = 1'b1;
    en  = 2'b00;
    #1;
    chk("mid_out", out, 2'b00);
    chk("mid_tick", tick, 2'b00);
    chk("mid_pending", pending, 2'b00);
    #1 rst = 1'b0;
    run = '{0, 0};
    ph  = '{0, 0};
    dv  = '{6, 6};
    hi  = '{3, 3};
    plan(1, 2'b00);
    stage = "after_rst";
    en = 2'b01;
    run[0] = 1;
    plan(12, 2'b00);

    // 6: pending load on ch1, then disable; shadow applied while idle.
    stage = "idle_apply";
    en = 2'b11;
    run[1] = 1; ph[1] = 0;
    plan(2, 2'b00);
    load = 2'b10; div_in[7:4] = 4'd4; high_in[7:4] = 4'd3;
    plan(1, 2'b10);
    load = 2'b00;
    en = 2'b01;
    run[1] = 0;
    plan(1, 2'b10);
    plan(1, 2'b00);
    en = 2'b11;
    run[1] = 1; ph[1] = 0;
    dv[1] = 4; hi[1] = 3;
    plan(8, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
